// File: rtl/spi_reg_arbiter.sv
// spi_reg_arbiter
//   Small register block shared by two requesters: an SPI slave running in
//   its own clock domain (raw read/write strobes) and a local requester in the
//   clk_32m domain. A two-state FSM serves one access per SERVE cycle.
//
// Ports
//   clk_32m, reset         system clock, asynchronous active-high reset
//   spi_re, spi_we         raw SPI strobes (asynchronous to clk_32m)
//   spi_addr, spi_wdat     SPI address / write data, stable while strobe high
//   spi_rdat               data returned to the SPI slave
//   loc_req, loc_we        local request (held until loc_done), write flag
//   loc_addr, loc_wdat     local address / write data
//   loc_gnt                high during the SERVE cycle of a local access
//   loc_done               one-cycle pulse after a local SERVE; loc_rdat valid
//   loc_rdat               local read data
//   gen_reg                general register value
//   err_addr               sticky: unknown address or write to read-only reg
//   overrun                sticky: an SPI strobe was lost
//
// Handshake: the local side asserts loc_req with stable loc_we/addr/wdat and
// keeps it high until it sees loc_done; loc_req is ignored while loc_done is
// high, so a requester that drops loc_req on seeing loc_done never gets a
// second, unintended service.
module spi_reg_arbiter #(
  parameter int         DW      = 96,
  parameter logic [6:0] A_STAT  = 7'h7C,
  parameter logic [6:0] A_GEN   = 7'h7D,
  parameter logic [6:0] A_RDCNT = 7'h7E,
  parameter logic [6:0] A_WRCNT = 7'h7F
) (
  input  logic          clk_32m,
  input  logic          reset,
  input  logic          spi_re,
  input  logic          spi_we,
  input  logic [6:0]    spi_addr,
  input  logic [DW-1:0] spi_wdat,
  output logic [DW-1:0] spi_rdat,
  input  logic          loc_req,
  input  logic          loc_we,
  input  logic [6:0]    loc_addr,
  input  logic [DW-1:0] loc_wdat,
  output logic          loc_gnt,
  output logic          loc_done,
  output logic [DW-1:0] loc_rdat,
  output logic [DW-1:0] gen_reg,
  output logic          err_addr,
  output logic          overrun
);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t state, state_nxt;

  // Strobe synchronizers and edge detectors
  logic re_s1, re_s2, re_d;
  logic we_s1, we_s2, we_d;
  // Shifts in ones after reset; edges are only honoured once both sync stages
  // and the edge register hold real samples, so a strobe already high at
  // reset release is never seen as a rising edge.
  logic [2:0] warm;
  logic re_pulse, we_pulse, any_pulse, drop_evt;

  // Captured SPI request
  logic          spi_pend;
  logic          spi_is_wr;
  logic [6:0]    spi_addr_q;
  logic [DW-1:0] spi_wdat_q;

  // Arbitration
  logic loc_act;
  logic pick_spi;
  logic contended;
  logic serve_spi;
  logic last_local;

  // Selected access
  logic          do_acc;
  logic          acc_wr;
  logic [6:0]    acc_addr;
  logic [DW-1:0] acc_wdat;
  logic [DW-1:0] rd_val;
  logic          addr_known, addr_ro;
  logic          err_set, stat_wr;

  logic [31:0] rd_cnt, wr_cnt;

  always_ff @(posedge clk_32m or posedge reset) begin
    if (reset) begin
      re_s1 <= 1'b0; re_s2 <= 1'b0; re_d <= 1'b0;
      we_s1 <= 1'b0; we_s2 <= 1'b0; we_d <= 1'b0;
      warm  <= 3'b000;
    end else begin
      re_s1 <= spi_re; re_s2 <= re_s1; re_d <= re_s2;
      we_s1 <= spi_we; we_s2 <= we_s1; we_d <= we_s2;
      warm  <= {warm[1:0], 1'b1};
    end
  end

  assign re_pulse  = re_s2 & ~re_d & warm[2];
  assign we_pulse  = we_s2 & ~we_d & warm[2];
  assign any_pulse = re_pulse | we_pulse;
  // Lost strobe: simultaneous read/write (read dropped) or edge while busy.
  assign drop_evt  = (re_pulse & we_pulse) | (any_pulse & spi_pend);

  // SPI request capture; the pending slot is released by its own SERVE.
  always_ff @(posedge clk_32m or posedge reset) begin
    if (reset) begin
      spi_pend   <= 1'b0;
      spi_is_wr  <= 1'b0;
      spi_addr_q <= '0;
      spi_wdat_q <= '0;
    end else if (any_pulse && !spi_pend) begin
      spi_pend   <= 1'b1;
      spi_is_wr  <= we_pulse;
      spi_addr_q <= spi_addr;
      spi_wdat_q <= spi_wdat;
    end else if (do_acc && serve_spi) begin
      spi_pend <= 1'b0;
    end
  end

  assign loc_act   = loc_req & ~loc_done;
  assign contended = spi_pend & loc_act;
  assign pick_spi  = spi_pend & (~loc_act | last_local);

  // FSM state register
  always_ff @(posedge clk_32m or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (spi_pend || loc_act) state_nxt = SERVE;
      SERVE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Winner is latched on entry to SERVE. last_served only moves on a real
  // contention, so the loser of one contention wins the next one even if it
  // was served uncontended in between.
  always_ff @(posedge clk_32m or posedge reset) begin
    if (reset) begin
      serve_spi  <= 1'b0;
      last_local <= 1'b1;
    end else if (state == IDLE && (spi_pend || loc_act)) begin
      serve_spi <= pick_spi;
      if (contended) last_local <= ~pick_spi;
    end
  end

  assign do_acc   = (state == SERVE);
  assign loc_gnt  = do_acc & ~serve_spi;
  assign acc_wr   = serve_spi ? spi_is_wr  : loc_we;
  assign acc_addr = serve_spi ? spi_addr_q : loc_addr;
  assign acc_wdat = serve_spi ? spi_wdat_q : loc_wdat;

  assign addr_ro    = (acc_addr == A_RDCNT) || (acc_addr == A_WRCNT);
  assign addr_known = addr_ro || (acc_addr == A_STAT) || (acc_addr == A_GEN);
  assign err_set    = do_acc & (~addr_known | (acc_wr & addr_ro));
  assign stat_wr    = do_acc & acc_wr & (acc_addr == A_STAT);

  // Read mux sees pre-access register values.
  always_comb begin
    rd_val = '0;
    if (acc_addr == A_GEN) begin
      rd_val = gen_reg;
    end else if (acc_addr == A_RDCNT) begin
      rd_val[31:0] = rd_cnt;
    end else if (acc_addr == A_WRCNT) begin
      rd_val[31:0] = wr_cnt;
    end else if (acc_addr == A_STAT) begin
      rd_val[1:0] = {overrun, err_addr};
    end
  end

  always_ff @(posedge clk_32m or posedge reset) begin
    if (reset) begin
      gen_reg  <= '0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      spi_rdat <= '0;
      loc_rdat <= '0;
      loc_done <= 1'b0;
      err_addr <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      loc_done <= do_acc & ~serve_spi;
      // Set has priority over write-1-to-clear.
      err_addr <= err_set  | (err_addr & ~(stat_wr & acc_wdat[0]));
      overrun  <= drop_evt | (overrun  & ~(stat_wr & acc_wdat[1]));
      if (do_acc && acc_wr && acc_addr == A_GEN) gen_reg <= acc_wdat;
      if (do_acc && acc_wr) wr_cnt <= wr_cnt + 32'd1;
      if (do_acc && serve_spi && !spi_is_wr) begin
        rd_cnt   <= rd_cnt + 32'd1;
        spi_rdat <= rd_val;
      end
      if (do_acc && !serve_spi && !loc_we) loc_rdat <= rd_val;
    end
  end

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// tb_spi_reg_arbiter
//   Directed bench for spi_reg_arbiter with hand-computed expectations.
module tb_spi_reg_arbiter;

  localparam int         DW      = 96;
  localparam logic [6:0] A_STAT  = 7'h7C;
  localparam logic [6:0] A_GEN   = 7'h7D;
  localparam logic [6:0] A_RDCNT = 7'h7E;
  localparam logic [6:0] A_WRCNT = 7'h7F;

  logic          clk_32m;
  logic          reset;
  logic          spi_re, spi_we;
  logic [6:0]    spi_addr;
  logic [DW-1:0] spi_wdat, spi_rdat;
  logic          loc_req, loc_we;
  logic [6:0]    loc_addr;
  logic [DW-1:0] loc_wdat, loc_rdat;
  logic          loc_gnt, loc_done;
  logic [DW-1:0] gen_reg;
  logic          err_addr, overrun;

  int n_tests = 0;
  int n_fail  = 0;

  spi_reg_arbiter #(
    .DW(DW), .A_STAT(A_STAT), .A_GEN(A_GEN), .A_RDCNT(A_RDCNT), .A_WRCNT(A_WRCNT)
  ) dut (
    .clk_32m (clk_32m),
    .reset   (reset),
    .spi_re  (spi_re),
    .spi_we  (spi_we),
    .spi_addr(spi_addr),
    .spi_wdat(spi_wdat),
    .spi_rdat(spi_rdat),
    .loc_req (loc_req),
    .loc_we  (loc_we),
    .loc_addr(loc_addr),
    .loc_wdat(loc_wdat),
    .loc_gnt (loc_gnt),
    .loc_done(loc_done),
    .loc_rdat(loc_rdat),
    .gen_reg (gen_reg),
    .err_addr(err_addr),
    .overrun (overrun)
  );

  // Clock / reset
  initial clk_32m = 1'b0;
  always #5 clk_32m = ~clk_32m;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk_32m);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk_32m);
  endtask

  // Driver tasks
  task automatic spi_write(input logic [6:0] addr, input logic [DW-1:0] wdat);
    @(posedge clk_32m); #1;
    spi_addr = addr; spi_wdat = wdat; spi_we = 1'b1;
    repeat (4) @(posedge clk_32m);
    #1 spi_we = 1'b0;
    repeat (6) @(posedge clk_32m);
    @(negedge clk_32m);
  endtask

  task automatic spi_read(input logic [6:0] addr);
    @(posedge clk_32m); #1;
    spi_addr = addr; spi_re = 1'b1;
    repeat (4) @(posedge clk_32m);
    #1 spi_re = 1'b0;
    repeat (6) @(posedge clk_32m);
    @(negedge clk_32m);
  endtask

  // Local access: checks grant arrives, loc_done one cycle after loc_gnt,
  // and loc_done is a single-cycle pulse.
  task automatic loc_access(input string tag, input logic we, input logic [6:0] addr,
                            input logic [DW-1:0] wdat);
    bit seen;
    seen = 1'b0;
    @(posedge clk_32m); #1;
    loc_we = we; loc_addr = addr; loc_wdat = wdat; loc_req = 1'b1;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk_32m);
      if (loc_gnt) seen = 1'b1;
    end
    check({tag, "_gnt"}, DW'(seen), DW'(1));
    if (seen) begin
      @(negedge clk_32m);
      check({tag, "_done"}, DW'(loc_done), DW'(1));
    end
    loc_req = 1'b0;
    @(negedge clk_32m);
    check({tag, "_done_end"}, DW'(loc_done), DW'(0));
    repeat (2) @(posedge clk_32m);
    @(negedge clk_32m);
  endtask

  // SPI read of A_GEN and local read of A_GEN pending in the same IDLE cycle.
  task automatic contend(input string tag, input logic local_first, input logic [DW-1:0] gen_val);
    @(posedge clk_32m); #1;            // P0
    spi_addr = A_GEN; spi_re = 1'b1;
    loc_we = 1'b0; loc_addr = A_GEN; loc_wdat = '0;
    repeat (3) @(posedge clk_32m);     // P3: spi_pend now set
    #1 loc_req = 1'b1;
    @(negedge clk_32m);                // still IDLE in P3..P4
    @(negedge clk_32m);                // SERVE in P4..P5
    check({tag, "_first_gnt"}, DW'(loc_gnt), DW'(local_first));
    if (local_first) begin
      @(negedge clk_32m);              // P5..P6
      check({tag, "_loc_done"}, DW'(loc_done), DW'(1));
      loc_req = 1'b0;
      @(negedge clk_32m);              // SPI SERVE P6..P7
      check({tag, "_second_gnt"}, DW'(loc_gnt), DW'(0));
      @(negedge clk_32m);
      check({tag, "_spi_rdat"}, spi_rdat, gen_val);
    end else begin
      @(negedge clk_32m);              // P5..P6: SPI result visible
      check({tag, "_spi_rdat"}, spi_rdat, gen_val);
      @(negedge clk_32m);              // local SERVE P6..P7
      check({tag, "_second_gnt"}, DW'(loc_gnt), DW'(1));
      @(negedge clk_32m);
      check({tag, "_loc_done"}, DW'(loc_done), DW'(1));
      loc_req = 1'b0;
    end
    check({tag, "_loc_rdat"}, loc_rdat, gen_val);
    spi_re = 1'b0;
    repeat (6) @(posedge clk_32m);
    @(negedge clk_32m);
  endtask

  bit seen_done;

  initial begin
    reset = 1'b1;
    spi_re = 1'b0; spi_we = 1'b0; spi_addr = '0; spi_wdat = '0;
    loc_req = 1'b0; loc_we = 1'b0; loc_addr = '0; loc_wdat = '0;
    repeat (3) @(posedge clk_32m);
    @(negedge clk_32m);
    check("rst_gen_reg", gen_reg, '0);
    check("rst_err", DW'(err_addr), '0);
    check("rst_overrun", DW'(overrun), '0);
    check("rst_loc_gnt", DW'(loc_gnt), '0);
    check("rst_loc_done", DW'(loc_done), '0);
    check("rst_spi_rdat", spi_rdat, '0);
    check("rst_loc_rdat", loc_rdat, '0);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk_32m);

    // Write then read A_GEN over SPI.
    spi_write(A_GEN, DW'(25000));
    check("gen_after_wr", gen_reg, DW'(25000));
    spi_read(A_GEN);
    check("spi_rd_gen", spi_rdat, DW'(25000));
    loc_access("l_rd_wrcnt1", 1'b0, A_WRCNT, '0);
    check("wr_cnt_1", loc_rdat, DW'(1));
    loc_access("l_rd_rdcnt1", 1'b0, A_RDCNT, '0);
    check("rd_cnt_1", loc_rdat, DW'(1));

    // Three reads of A_RDCNT from a fresh reset.
    do_reset();
    spi_read(A_RDCNT);
    check("rdcnt_seq0", spi_rdat, DW'(0));
    spi_read(A_RDCNT);
    check("rdcnt_seq1", spi_rdat, DW'(1));
    spi_read(A_RDCNT);
    check("rdcnt_seq2", spi_rdat, DW'(2));
    loc_access("l_rd_rdcnt3", 1'b0, A_RDCNT, '0);
    check("rd_cnt_3", loc_rdat, DW'(3));

    // Contention, twice: SPI first, then local first.
    spi_write(A_GEN, DW'(32'h1234));          // wr_cnt = 1
    contend("cont1", 1'b0, DW'(32'h1234));    // rd_cnt = 4
    contend("cont2", 1'b1, DW'(32'h1234));    // rd_cnt = 5

    // Second read edge while the first is still pending.
    @(posedge clk_32m); #1;
    spi_addr = A_GEN; spi_re = 1'b1;
    @(posedge clk_32m); #1 spi_re = 1'b0;
    @(posedge clk_32m); #1 spi_re = 1'b1;
    repeat (6) @(posedge clk_32m);
    #1 spi_re = 1'b0;
    repeat (6) @(posedge clk_32m);
    @(negedge clk_32m);
    check("ovr_set", DW'(overrun), DW'(1));
    check("ovr_err_clean", DW'(err_addr), DW'(0));
    spi_write(A_STAT, DW'(2));                // wr_cnt = 2
    check("ovr_clear", DW'(overrun), DW'(0));

    // Read and write strobes together: write wins, overrun set.
    @(posedge clk_32m); #1;
    spi_addr = A_GEN; spi_wdat = DW'(77); spi_re = 1'b1; spi_we = 1'b1;
    repeat (4) @(posedge clk_32m);
    #1 begin spi_re = 1'b0; spi_we = 1'b0; end
    repeat (6) @(posedge clk_32m);
    @(negedge clk_32m);
    check("rw_gen", gen_reg, DW'(77));        // wr_cnt = 3
    check("rw_ovr", DW'(overrun), DW'(1));
    spi_write(A_STAT, DW'(2));                // wr_cnt = 4
    loc_access("l_rd_rdcnt5", 1'b0, A_RDCNT, '0);
    check("rd_cnt_rw", loc_rdat, DW'(6));

    // Local write to a read-only register.
    loc_access("l_wr_wrcnt", 1'b1, A_WRCNT, DW'(99));   // wr_cnt = 5
    check("ro_err", DW'(err_addr), DW'(1));
    loc_access("l_rd_wrcnt5", 1'b0, A_WRCNT, '0);
    check("wr_cnt_5", loc_rdat, DW'(5));
    spi_write(A_STAT, DW'(1));                // wr_cnt = 6
    check("err_clear", DW'(err_addr), DW'(0));
    spi_read(7'h10);                          // rd_cnt = 7
    check("unk_rdat", spi_rdat, DW'(0));
    check("unk_err", DW'(err_addr), DW'(1));
    spi_read(A_STAT);                         // rd_cnt = 8
    check("stat_rd", spi_rdat, DW'(1));
    loc_access("l_rd_rdcnt8", 1'b0, A_RDCNT, '0);
    check("rd_cnt_8", loc_rdat, DW'(8));

    // Reset in the middle of a local SERVE.
    loc_access("l_wr_gen5", 1'b1, A_GEN, DW'(5));
    check("gen_5", gen_reg, DW'(5));
    @(posedge clk_32m); #1;
    loc_we = 1'b1; loc_addr = A_GEN; loc_wdat = DW'(9); loc_req = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 30 && !loc_gnt; i++) @(negedge clk_32m);
    check("mid_gnt", DW'(loc_gnt), DW'(1));
    #1 reset = 1'b1;
    #1;
    check("mid_rst_gen", gen_reg, '0);
    check("mid_rst_gnt", DW'(loc_gnt), '0);
    check("mid_rst_done", DW'(loc_done), '0);
    check("mid_rst_err", DW'(err_addr), '0);
    check("mid_rst_loc_rdat", loc_rdat, '0);
    loc_req = 1'b0;
    // Write strobe already high when reset is released.
    spi_addr = A_GEN; spi_wdat = DW'(7); spi_we = 1'b1;
    repeat (2) @(posedge clk_32m);
    #1 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_32m);
      if (loc_done) seen_done = 1'b1;
    end
    check("no_done_after_rst", DW'(seen_done), DW'(0));
    check("held_strobe_gen", gen_reg, '0);
    spi_we = 1'b0;
    repeat (4) @(posedge clk_32m);
    loc_access("l_rd_wrcnt0", 1'b0, A_WRCNT, '0);
    check("held_strobe_wrcnt", loc_rdat, DW'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/spi_reg_arbiter.md
SPI_REG_ARBITER -- requirements
Module: spi_reg_arbiter

Interface
REQ-001 Parameter DW, default 96: register and data width in bits; DW >= 32.
REQ-002 Parameter A_STAT, default 7'h7C: status register address (read / write-1-to-clear).
REQ-003 Parameter A_GEN, default 7'h7D: general register address (read/write).
REQ-004 Parameter A_RDCNT, default 7'h7E: SPI read counter address (read-only).
REQ-005 Parameter A_WRCNT, default 7'h7F: write counter address (read-only).
REQ-006 Clock and reset SHALL be: reset reset, asynchronous, active-high; clock clk_32m.
REQ-007 clk_32m  in  1  system clock.
REQ-008 reset  in  1  asynchronous active-high reset.
REQ-009 spi_re  in  1  raw read strobe from SPI slave, SPI clock domain.
REQ-010 spi_we  in  1  raw write strobe from SPI slave, SPI clock domain.
REQ-011 spi_addr  in  7  SPI register address, stable while strobe high.
REQ-012 spi_wdat  in  DW  SPI write data, stable while spi_we high.
REQ-013 spi_rdat  out  DW  read data returned to SPI slave.
REQ-014 loc_req  in  1  local requester access request, held until loc_done.
REQ-015 loc_we  in  1  local access is write (1) or read (0).
REQ-016 loc_addr  in  7  local register address.
REQ-017 loc_wdat  in  DW  local write data.
REQ-018 loc_gnt  out  1  high during the SERVE cycle of a local access.
REQ-019 loc_done  out  1  one-cycle pulse, cycle after local SERVE; loc_rdat valid.
REQ-020 loc_rdat  out  DW  local read data.
REQ-021 gen_reg  out  DW  current general register value.
REQ-022 err_addr  out  1  sticky: access to unknown address or write to read-only register.
REQ-023 overrun  out  1  sticky: SPI strobe lost.

Function
REQ-024 spi_re and spi_we SHALL each pass a 2-flop synchronizer, then a rising-edge detector producing a single-cycle pulse.
REQ-025 On an edge pulse, spi_addr and spi_wdat SHALL be captured and spi_pend set the following cycle.
REQ-026 Read and write edge pulses in the same cycle: write accepted, read dropped, overrun set.
REQ-027 Edge pulse while spi_pend already set: new request dropped, overrun set, pending request unaffected.
REQ-028 FSM states IDLE, SERVE; IDLE->SERVE when spi_pend or loc_req; SERVE->IDLE unconditionally.
REQ-029 Both pending in IDLE: round-robin against last_served; last_served resets to LOCAL so SPI wins first contention.
REQ-030 Uncontended SPI access: SERVE exactly 1 cycle after spi_pend set; spi_rdat and register updates visible the cycle after SERVE; spi_pend cleared then.
REQ-031 loc_req is sampled only in IDLE; loc_gnt high for the whole SERVE cycle when local selected.
REQ-032 Read returns pre-access value: A_GEN -> gen_reg, A_RDCNT -> rd_cnt, A_WRCNT -> wr_cnt, A_STAT -> {zero-fill, overrun, err_addr}.
REQ-033 Read of unknown address returns 0 and sets err_addr.
REQ-034 Write A_GEN loads gen_reg; write A_STAT clears err_addr/overrun where wdat[0]/wdat[1] = 1.
REQ-035 Write A_RDCNT, A_WRCNT or unknown address: no register change, err_addr set.
REQ-036 rd_cnt (32-bit, zero-extended to DW) increments by 1 on every served SPI read, any address; wraps 0xFFFFFFFF->0.
REQ-037 wr_cnt (32-bit, zero-extended) increments on every served write from either requester, including rejected writes.
REQ-038 Error set and write-1-to-clear in the same cycle: set wins.
REQ-039 spi_rdat changes only on served SPI reads; loc_rdat only on served local reads.

Reset
REQ-040 Reset SHALL asynchronously force: FSM IDLE, synchronizers and edge detectors 0, spi_pend 0, last_served LOCAL, gen_reg 0, rd_cnt 0, wr_cnt 0, spi_rdat 0, loc_rdat 0, loc_gnt 0, loc_done 0, err_addr 0, overrun 0.
REQ-041 Reset mid-SERVE SHALL abort the access with no register or counter update; no loc_done issued.
REQ-042 A strobe already high at reset release SHALL NOT produce an edge pulse.

Verification
REQ-043 SPI write A_GEN wdat=25000, then SPI read A_GEN -> spi_rdat=25000, wr_cnt=1, rd_cnt=1.
REQ-044 Three SPI reads of A_RDCNT -> spi_rdat 0, 1, 2 in order; rd_cnt=3.
REQ-045 SPI read and loc_req pending same IDLE cycle, twice -> SPI served first, then local, then local first on next contention.
REQ-046 Second spi_re edge before first served -> overrun=1; SPI write A_STAT wdat=2 -> overrun=0.
REQ-047 Local write to A_WRCNT -> err_addr=1, wr_cnt increments, loc_done pulse one cycle after loc_gnt.
REQ-048 Assert reset during local SERVE after gen_reg=5 -> all outputs 0, no loc_done, gen_reg=0.
